mul_exe_pipe: RTL and testbench

- Two-stage pipelined multiply execution unit between the MUL reservation-station issue port and the CDB arbiter.
- Registers the issued operands and drives the existing combinational `multiplier` from them.
- Registers the selected 32-bit result with its destination RRF tag.
- Holds the result under CDB backpressure and squashes speculative ops on branch mispredict.

---
 rtl/mul_exe_pipe_pkg.sv | 46 ++++
 rtl/mul_exe_pipe_if.sv | 40 ++++
 rtl/mul_pipe_slot.sv | 52 +++++
 rtl/multiplier.sv | 35 +++
 rtl/mul_exe_pipe.sv | 144 ++++++++++++++
 tb/tb_mul_exe_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_exe_pipe_pkg.sv
// ============================================================================
//  Module   : mul_exe_pipe_pkg
//  Brief    : Shared widths, the S1 operand bundle type and the
//             speculative-tag helper functions for the multiply pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MUL_LATENCY
`define MUL_LATENCY 2
`endif

package mul_exe_pipe_pkg;

   localparam int DATA_LEN    = 32;
   localparam int RRF_SEL     = 6;
   localparam int SPECTAG_LEN = 5;

   // Operand bundle latched in stage 1 and presented to the multiplier
   typedef struct packed {
      logic [DATA_LEN-1:0] src1;
      logic [DATA_LEN-1:0] src2;
      logic                src1_signed;
      logic                src2_signed;
      logic                sel_lohi;
      logic [RRF_SEL-1:0]  rrftag;
   } mul_op_t;

   // An op is squashed when it depends on the mispredicted branch
   function automatic logic tag_hit(input logic [SPECTAG_LEN-1:0] spectag,
                                    input logic [SPECTAG_LEN-1:0] prtag);
      return (spectag & prtag) != '0;
   endfunction

   // A correctly resolved branch drops its bit; a mispredict takes priority
   function automatic logic [SPECTAG_LEN-1:0] spec_fix(
      input logic [SPECTAG_LEN-1:0] spectag,
      input logic                   prmiss,
      input logic                   prsuccess,
      input logic [SPECTAG_LEN-1:0] specfixtag);
      return (prsuccess && !prmiss) ? (spectag & ~specfixtag) : spectag;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_exe_pipe_if.sv
// ============================================================================
//  Module   : mul_exe_pipe_if
//  Brief    : Issue-port and CDB-side handshake bundle of the multiply pipe.
//             master = RS/CDB side, slave = execution unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_exe_pipe_if;
   import mul_exe_pipe_pkg::*;

   logic                   issue_valid;
   logic                   issue_ready;
   logic [DATA_LEN-1:0]    src1;
   logic [DATA_LEN-1:0]    src2;
   logic                   src1_signed;
   logic                   src2_signed;
   logic                   sel_lohi;
   logic [RRF_SEL-1:0]     rrftag;
   logic [SPECTAG_LEN-1:0] spectag;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_LEN-1:0]    out_result;
   logic [RRF_SEL-1:0]     out_rrftag;

   modport master (
      output issue_valid, src1, src2, src1_signed, src2_signed, sel_lohi,
             rrftag, spectag, out_ready,
      input  issue_ready, out_valid, out_result, out_rrftag
   );

   modport slave (
      input  issue_valid, src1, src2, src1_signed, src2_signed, sel_lohi,
             rrftag, spectag, out_ready,
      output issue_ready, out_valid, out_result, out_rrftag
   );

endinterface

`default_nettype wire

// File: rtl/mul_pipe_slot.sv
// ============================================================================
//  Module   : mul_pipe_slot
//  Brief    : Valid bit and speculative tag of one pipeline stage, with
//             mispredict kill and branch-success tag clearing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_pipe_slot
   import mul_exe_pipe_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   in_valid,
   input  logic [SPECTAG_LEN-1:0] in_spectag,
   input  logic                   prmiss,
   input  logic                   prsuccess,
   input  logic [SPECTAG_LEN-1:0] prtag,
   input  logic [SPECTAG_LEN-1:0] specfixtag,
   output logic                   valid,
   output logic [SPECTAG_LEN-1:0] spectag,
   output logic                   kill
);

   logic in_kill;

   assign in_kill = prmiss && tag_hit(in_spectag, prtag);
   assign kill    = valid && prmiss && tag_hit(spectag, prtag);

   // Take the incoming op when advancing, otherwise hold; kills and tag
   // fixes apply to whichever op ends up resident after the edge
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= 1'b0;
         spectag <= '0;
      end else if (load) begin
         valid <= in_valid && !in_kill;
         if (in_valid) begin
            spectag <= spec_fix(in_spectag, prmiss, prsuccess, specfixtag);
         end
      end else begin
         if (kill) begin
            valid <= 1'b0;
         end
         spectag <= spec_fix(spectag, prmiss, prsuccess, specfixtag);
      end
   end

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
//  Module   : multiplier
//  Brief    : Combinational DATA_LEN x DATA_LEN multiplier with per-operand
//             signedness; sel_lohi picks the high or low half of the product.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
   parameter int DATA_LEN = 32
) (
   input  logic [DATA_LEN-1:0] src1,
   input  logic [DATA_LEN-1:0] src2,
   input  logic                src1_signed,
   input  logic                src2_signed,
   input  logic                sel_lohi,
   output logic [DATA_LEN-1:0] result
);

   logic [2*DATA_LEN-1:0] ext1;
   logic [2*DATA_LEN-1:0] ext2;
   logic [2*DATA_LEN-1:0] product;

   // Extending both operands to the full product width makes the truncated
   // product exact modulo 2^(2*DATA_LEN) for every signedness combination
   always_comb begin
      ext1    = {{DATA_LEN{src1_signed & src1[DATA_LEN-1]}}, src1};
      ext2    = {{DATA_LEN{src2_signed & src2[DATA_LEN-1]}}, src2};
      product = ext1 * ext2;
      result  = sel_lohi ? product[2*DATA_LEN-1:DATA_LEN] : product[DATA_LEN-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/mul_exe_pipe.sv
// ============================================================================
//  Module   : mul_exe_pipe
//  Brief    : Two-stage multiply execution unit between the MUL reservation
//             station and the CDB arbiter. S1 registers operands, the
//             combinational multiplier feeds S2, S2 holds the result under
//             CDB backpressure. Speculative ops are squashed on mispredict.
//  Options  : MUL_EXE_PIPE_PERF_CNT_EN adds issue/stall performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_exe_pipe
   import mul_exe_pipe_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   mul_exe_pipe_if.slave          bus,
   input  logic                   prmiss,
   input  logic                   prsuccess,
   input  logic [SPECTAG_LEN-1:0] prtag,
   input  logic [SPECTAG_LEN-1:0] specfixtag
`ifdef MUL_EXE_PIPE_PERF_CNT_EN
   ,
   output logic [31:0]            perf_issue_cnt,
   output logic [31:0]            perf_stall_cnt
`endif
);

   logic                   adv1;
   logic                   adv2;
   logic                   v1;
   logic                   v2;
   logic                   kill1;
   logic                   kill2;
   logic [SPECTAG_LEN-1:0] spectag1;
   logic [SPECTAG_LEN-1:0] spectag2;
   logic                   issue_fire;
   logic                   s1_load;
   logic                   s2_load;
   logic                   out_valid;
   mul_op_t                op1;
   logic [DATA_LEN-1:0]    mul_result;
   logic [DATA_LEN-1:0]    result2;
   logic [RRF_SEL-1:0]     rrftag2;

   assign adv2       = !v2 || bus.out_ready;
   assign adv1       = !v1 || adv2;
   assign issue_fire = bus.issue_valid && adv1;
   // Datapath registers only move for ops that survive the transfer
   assign s1_load    = issue_fire && !(prmiss && tag_hit(bus.spectag, prtag));
   assign s2_load    = adv2 && v1 && !kill1;
   // A result being squashed this cycle must never be granted
   assign out_valid  = v2 && !kill2;

   assign bus.issue_ready = adv1;
   assign bus.out_valid   = out_valid;
   assign bus.out_result  = result2;
   assign bus.out_rrftag  = rrftag2;

   mul_pipe_slot u_slot1 (
      .clk        (clk),
      .reset      (reset),
      .load       (adv1),
      .in_valid   (bus.issue_valid),
      .in_spectag (bus.spectag),
      .prmiss     (prmiss),
      .prsuccess  (prsuccess),
      .prtag      (prtag),
      .specfixtag (specfixtag),
      .valid      (v1),
      .spectag    (spectag1),
      .kill       (kill1)
   );

   mul_pipe_slot u_slot2 (
      .clk        (clk),
      .reset      (reset),
      .load       (adv2),
      .in_valid   (v1),
      .in_spectag (spectag1),
      .prmiss     (prmiss),
      .prsuccess  (prsuccess),
      .prtag      (prtag),
      .specfixtag (specfixtag),
      .valid      (v2),
      .spectag    (spectag2),
      .kill       (kill2)
   );

   multiplier #(
      .DATA_LEN (DATA_LEN)
   ) u_multiplier (
      .src1        (op1.src1),
      .src2        (op1.src2),
      .src1_signed (op1.src1_signed),
      .src2_signed (op1.src2_signed),
      .sel_lohi    (op1.sel_lohi),
      .result      (mul_result)
   );

   // Operand capture into S1 and result capture into S2
   always_ff @(posedge clk) begin
      if (reset) begin
         op1     <= '0;
         result2 <= '0;
         rrftag2 <= '0;
      end else begin
         if (s1_load) begin
            op1.src1        <= bus.src1;
            op1.src2        <= bus.src2;
            op1.src1_signed <= bus.src1_signed;
            op1.src2_signed <= bus.src2_signed;
            op1.sel_lohi    <= bus.sel_lohi;
            op1.rrftag      <= bus.rrftag;
         end
         if (s2_load) begin
            result2 <= mul_result;
            rrftag2 <= op1.rrftag;
         end
      end
   end

`ifdef MUL_EXE_PIPE_PERF_CNT_EN
   // Accepted-issue and CDB-stall counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue_fire) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if (out_valid && !bus.out_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`else
   // Counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_exe_pipe.sv
// ============================================================================
//  Module   : tb_mul_exe_pipe
//  Brief    : Self-checking bench for mul_exe_pipe: vector table plus
//             hand-written stall, kill, branch-success and reset sequences,
//             with a queue scoreboard checked at every CDB grant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_exe_pipe;
   import mul_exe_pipe_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   prmiss = 1'b0;
   logic                   prsuccess = 1'b0;
   logic [SPECTAG_LEN-1:0] prtag = '0;
   logic [SPECTAG_LEN-1:0] specfixtag = '0;
`ifdef MUL_EXE_PIPE_PERF_CNT_EN
   logic [31:0]            perf_issue_cnt;
   logic [31:0]            perf_stall_cnt;
`endif

   mul_exe_pipe_if bus ();

   mul_exe_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .prmiss     (prmiss),
      .prsuccess  (prsuccess),
      .prtag      (prtag),
      .specfixtag (specfixtag)
`ifdef MUL_EXE_PIPE_PERF_CNT_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [5:0]  tag;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        as;
      logic        bs;
      logic        hi;
      logic [5:0]  tag;
      logic [31:0] exp;
   } vec_t;

   exp_t  sb[$];
   exp_t  mon_e;
   vec_t  vecs[12];
   int    errors = 0;
   int    checks = 0;
   int    n_issued = 0;
   int    n_stall = 0;
   longint t0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
   endtask

   // Drive one op and wait for its acceptance; alive=0 means it is expected
   // to be squashed and must never reach the CDB
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic as, input logic bs, input logic hi,
                        input logic [5:0] tag, input logic [4:0] st,
                        input logic [31:0] exp, input bit alive);
      bit acc = 1'b0;
      bus.issue_valid = 1'b1;
      bus.src1        = a;
      bus.src2        = b;
      bus.src1_signed = as;
      bus.src2_signed = bs;
      bus.sel_lohi    = hi;
      bus.rrftag      = tag;
      bus.spectag     = st;
      for (int i = 0; i < 30 && !acc; i++) begin
         @(negedge clk);
         if (bus.issue_ready) begin
            acc = 1'b1;
            n_issued++;
            if (alive) sb.push_back('{res: exp, tag: tag});
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: actual=not accepted required=accepted tag=%0d", tag);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      check(name, 64'(sb.size()), 64'd0);
   endtask

   // CDB-side monitor: every grant must match the oldest expected result
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && !bus.out_ready) n_stall++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: actual tag=%0d result=%h required=no output",
                        bus.out_rrftag, bus.out_result);
            end else begin
               mon_e = sb.pop_front();
               check("result", 64'(bus.out_result), 64'(mon_e.res));
               check("rrftag", 64'(bus.out_rrftag), 64'(mon_e.tag));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 6'd1,  32'hFFFFFFFE};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 6'd2,  32'h00000001};
      vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 6'd3,  32'h00000000};
      vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 6'd4,  32'h40000000};
      vecs[4]  = '{32'h80000000, 32'h00000002, 1'b1, 1'b0, 1'b1, 6'd5,  32'hFFFFFFFF};
      vecs[5]  = '{32'h80000000, 32'h00000002, 1'b0, 1'b0, 1'b1, 6'd6,  32'h00000001};
      vecs[6]  = '{32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0, 6'd7,  32'h00000000};
      vecs[7]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 6'd8,  32'h00000001};
      vecs[8]  = '{32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 6'd9,  32'hFFFFFFF9};
      vecs[9]  = '{32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 6'd10, 32'hFFFFFFFF};
      vecs[10] = '{32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 6'd11, 32'h00000006};
      vecs[11] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 6'd12, 32'hC0000000};

      bus.issue_valid = 1'b0;
      bus.src1        = '0;
      bus.src2        = '0;
      bus.src1_signed = 1'b0;
      bus.src2_signed = 1'b0;
      bus.sel_lohi    = 1'b0;
      bus.rrftag      = '0;
      bus.spectag     = '0;
      bus.out_ready   = 1'b1;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid",   64'(bus.out_valid),   64'd0);
      check("rst_out_result",  64'(bus.out_result),  64'd0);
      check("rst_out_rrftag",  64'(bus.out_rrftag),  64'd0);
      check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
      tick();

      // Two-edge latency of a single signed op
      issue(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 1'b0, 6'd3, 5'b0, 32'hFFFFFFF1, 1'b1);
      idle();
      @(negedge clk);
      check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
      tick();
      @(negedge clk);
      check("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
      tick();
      drain("lat_drain");

      // Vector table issued back-to-back at full rate
      t0 = $time;
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].hi,
               vecs[i].tag, 5'b0, vecs[i].exp, 1'b1);
      end
      check("throughput_cycles", 64'(($time - t0) / 10), 64'd12);
      idle();
      drain("table_drain");

      // Backpressure: three ops against a stalled CDB
      bus.out_ready = 1'b0;
      issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 6'd40, 5'b0, 32'd12, 1'b1);
      issue(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 6'd41, 5'b0, 32'd42, 1'b1);
      fork
         issue(32'd100, 32'd100, 1'b0, 1'b0, 1'b0, 6'd42, 5'b0, 32'd10000, 1'b1);
         begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check("stall_issue_ready", 64'(bus.issue_ready), 64'd0);
               check("stall_out_valid",   64'(bus.out_valid),   64'd1);
               check("stall_out_result",  64'(bus.out_result),  64'd12);
               check("stall_out_rrftag",  64'(bus.out_rrftag),  64'd40);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle();
      drain("stall_drain");

      // Mispredict kills B in S1 while A in S2 retires
      issue(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 6'd20, 5'b00010, 32'd6, 1'b1);
      issue(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 6'd21, 5'b00100, 32'd25, 1'b0);
      idle();
      prmiss = 1'b1;
      prtag  = 5'b00100;
      @(negedge clk);
      check("kill_a_valid", 64'(bus.out_valid), 64'd1);
      tick();
      prmiss = 1'b0;
      prtag  = '0;
      @(negedge clk);
      check("kill_b_gone", 64'(bus.out_valid), 64'd0);
      tick();
      check("kill_sb_empty", 64'(sb.size()), 64'd0);

      // A stalled S2 result hit by a mispredict is masked at once
      bus.out_ready = 1'b0;
      issue(32'd8, 32'd8, 1'b0, 1'b0, 1'b0, 6'd22, 5'b01000, 32'd64, 1'b0);
      idle();
      tick();
      prmiss = 1'b1;
      prtag  = 5'b01000;
      @(negedge clk);
      check("kill_s2_masked", 64'(bus.out_valid), 64'd0);
      tick();
      prmiss = 1'b0;
      prtag  = '0;
      @(negedge clk);
      check("kill_s2_cleared", 64'(bus.out_valid), 64'd0);
      tick();
      bus.out_ready = 1'b1;

      // Incoming op on a mispredicted path is accepted but dropped
      prmiss = 1'b1;
      prtag  = 5'b10000;
      issue(32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 6'd23, 5'b10000, 32'd18, 1'b0);
      prmiss = 1'b0;
      prtag  = '0;
      idle();
      tick();
      @(negedge clk);
      check("kill_incoming", 64'(bus.out_valid), 64'd0);
      tick();

      // Branch success clears the tag, so a later mispredict spares the op
      bus.out_ready = 1'b0;
      issue(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 6'd30, 5'b00010, 32'd81, 1'b1);
      idle();
      tick();
      prsuccess  = 1'b1;
      specfixtag = 5'b00010;
      @(negedge clk);
      check("psucc_valid", 64'(bus.out_valid), 64'd1);
      tick();
      prsuccess  = 1'b0;
      specfixtag = '0;
      prmiss     = 1'b1;
      prtag      = 5'b00010;
      @(negedge clk);
      check("psucc_survive", 64'(bus.out_valid), 64'd1);
      tick();
      prmiss = 1'b0;
      prtag  = '0;
      bus.out_ready = 1'b1;
      drain("psucc_drain");

`ifdef MUL_EXE_PIPE_PERF_CNT_EN
      check("perf_issue_cnt", 64'(perf_issue_cnt), 64'(n_issued));
      check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(n_stall));
`endif

      // Reset with both stages full drops everything in flight
      bus.out_ready = 1'b0;
      issue(32'd11, 32'd11, 1'b0, 1'b0, 1'b0, 6'd50, 5'b0, 32'd121, 1'b0);
      issue(32'd12, 32'd12, 1'b0, 1'b0, 1'b0, 6'd51, 5'b0, 32'd144, 1'b0);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst2_out_valid",   64'(bus.out_valid),   64'd0);
      check("rst2_issue_ready", 64'(bus.issue_ready), 64'd1);
      check("rst2_out_result",  64'(bus.out_result),  64'd0);
`ifdef MUL_EXE_PIPE_PERF_CNT_EN
      check("rst2_perf_issue", 64'(perf_issue_cnt), 64'd0);
      check("rst2_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
      tick();
      bus.out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("rst2_dropped", 64'(bus.out_valid), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
